// File: rtl/scalar_wb_pkg.sv
// Shared constants and the writeback request type used by the FIFO and the arbiter.
package scalar_wb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // True for addresses that map to a real, writable register (x0 is hardwired).
    function automatic logic addr_writable(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < NUM_REGS);
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Memory-result FIFO: power-of-two depth, pointers carry an extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module wb_result_fifo
    import scalar_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

    logic [PtrW:0] wr_q;
    logic [PtrW:0] rd_q;
    wb_req_t       mem_q [DEPTH];

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    assign head  = mem_q[rd_q[PtrW-1:0]];

    // Pointer and storage update; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full) begin
                mem_q[wr_q[PtrW-1:0]] <= push_req;
                wr_q                  <= wr_q + PtrOne;
            end
            if (pop && !empty) begin
                rd_q <= rd_q + PtrOne;
            end
        end
    end

endmodule

// File: rtl/scalar_writeback_unit.sv
// Scalar writeback stage: arbitrates ALU results (priority) and buffered load
// results onto the register-file write port, and tracks pending loads per
// register for load-use hazard detection.
// Optional macro WB_BYPASS_EN adds same-cycle forwarding outputs fwd1/fwd2.
module scalar_writeback_unit
    import scalar_wb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 4,
    parameter int unsigned PEND_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              WriteEn,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] InputData,
    output logic              err_addr
`ifdef WB_BYPASS_EN
    ,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
`endif
);

    localparam logic [PEND_W-1:0] PendMax = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

    wb_req_t fifo_head;
    wb_req_t mem_req;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_push;
    logic    fifo_pop;

    wb_req_t sel_req;
    logic    sel_valid;

    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];

    assign mem_req.rd   = mem_rd;
    assign mem_req.data = mem_data;

    // Ready depends only on registered FIFO state; a pop cannot free a slot same-cycle.
    assign mem_ready = !fifo_full;
    assign fifo_push = mem_valid && mem_ready;
    assign fifo_pop  = !alu_valid && !fifo_empty;

    wb_result_fifo #(
        .DEPTH (MEM_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_req (mem_req),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Arbiter: ALU always wins, otherwise drain the FIFO head.
    always_comb begin
        sel_valid = 1'b0;
        sel_req   = '0;
        if (alu_valid) begin
            sel_valid    = 1'b1;
            sel_req.rd   = alu_rd;
            sel_req.data = alu_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_req   = fifo_head;
        end
    end

    // Output register with address filtering and sticky out-of-range error.
    always_ff @(posedge clk) begin
        if (rst) begin
            WriteEn   <= 1'b0;
            rd        <= '0;
            InputData <= '0;
            err_addr  <= 1'b0;
        end else begin
            WriteEn <= sel_valid && addr_writable(sel_req.rd);
            if (sel_valid) begin
                rd        <= sel_req.rd;
                InputData <= sel_req.data;
            end
            if (sel_valid && (32'(sel_req.rd) >= NUM_REGS)) begin
                err_addr <= 1'b1;
            end
        end
    end

    // Pending-load counters: issue increments, retire decrements, both cancel.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_d[i] = pend_q[i];
        end
        pend_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            logic inc;
            logic dec;
            inc = ld_issue && (ld_rd == ADDR_W'(i));
            dec = fifo_pop && (fifo_head.rd == ADDR_W'(i));
            if (inc && !dec && (pend_q[i] != PendMax)) begin
                pend_d[i] = pend_q[i] + PendOne;
            end else if (dec && !inc && (pend_q[i] != '0)) begin
                pend_d[i] = pend_q[i] - PendOne;
            end
        end
    end

    // Counter state; reset also drops any load issued in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    // Hazard query; x0 and out-of-range addresses never match a counter.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if ((q_rs1 == ADDR_W'(i)) && (pend_q[i] != '0)) begin
                rs1_busy = 1'b1;
            end
            if ((q_rs2 == ADDR_W'(i)) && (pend_q[i] != '0)) begin
                rs2_busy = 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle; the register file still returns the old one.
    assign fwd1_hit  = WriteEn && (rd == q_rs1) && (q_rs1 != '0);
    assign fwd2_hit  = WriteEn && (rd == q_rs2) && (q_rs2 != '0);
    assign fwd1_data = InputData;
    assign fwd2_data = InputData;
`endif

endmodule

// File: tb/tb_scalar_writeback_unit.sv
// Directed bench for scalar_writeback_unit with a write-order scoreboard.
module tb_scalar_writeback_unit;
    import scalar_wb_pkg::*;

    localparam int Depth   = 4;
    localparam int PendMax = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              ld_issue = 1'b0;
    logic [ADDR_W-1:0] ld_rd = '0;
    logic [ADDR_W-1:0] q_rs1 = '0;
    logic [ADDR_W-1:0] q_rs2 = '0;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              WriteEn;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] InputData;
    logic              err_addr;

    always #5 clk = ~clk;

    scalar_writeback_unit #(
        .MEM_DEPTH (Depth),
        .PEND_W    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .ld_issue  (ld_issue),
        .ld_rd     (ld_rd),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .WriteEn   (WriteEn),
        .rd        (rd),
        .InputData (InputData),
        .err_addr  (err_addr)
    );

    int      total  = 0;
    int      passed = 0;
    wb_req_t exp_q[$];
    wb_req_t mf[$];
    int      pend[NUM_REGS];
    logic    err_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int reg_idx(input logic [ADDR_W-1:0] a);
        if (a != '0 && 32'(a) < NUM_REGS) return int'(a);
        return -1;
    endfunction

    function automatic logic busy_m(input logic [ADDR_W-1:0] a);
        int k;
        k = reg_idx(a);
        return (k > 0) && (pend[k] != 0);
    endfunction

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        ld_issue  = 1'b0;
    endtask

    // Predict this cycle's effect from the current inputs, clock it, then check.
    task automatic cycle(input string tag);
        wb_req_t sel;
        wb_req_t e;
        wb_req_t m;
        bit      sv;
        bit      ready;
        int      issue;
        int      retire;
        ready  = (mf.size() < Depth);
        sv     = 1'b0;
        retire = -1;
        sel    = '0;
        if (alu_valid) begin
            sv       = 1'b1;
            sel.rd   = alu_rd;
            sel.data = alu_data;
        end else if (mf.size() > 0) begin
            sv     = 1'b1;
            sel    = mf.pop_front();
            retire = reg_idx(sel.rd);
        end
        if (mem_valid && ready) begin
            m.rd   = mem_rd;
            m.data = mem_data;
            mf.push_back(m);
        end
        if (sv && reg_idx(sel.rd) > 0) exp_q.push_back(sel);
        if (sv && 32'(sel.rd) >= NUM_REGS) err_m = 1'b1;
        issue = ld_issue ? reg_idx(ld_rd) : -1;
        if (issue != retire) begin
            if (issue > 0 && pend[issue] < PendMax) pend[issue]++;
            if (retire > 0 && pend[retire] > 0) pend[retire]--;
        end
        @(posedge clk);
        #1;
        chk({tag, ".we"}, 64'(WriteEn), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".rd"}, 64'(rd), 64'(e.rd));
            chk({tag, ".data"}, 64'(InputData), 64'(e.data));
        end
        chk({tag, ".ready"}, 64'(mem_ready), 64'(mf.size() < Depth));
        chk({tag, ".busy1"}, 64'(rs1_busy), 64'(busy_m(q_rs1)));
        chk({tag, ".busy2"}, 64'(rs2_busy), 64'(busy_m(q_rs2)));
        chk({tag, ".err"}, 64'(err_addr), 64'(err_m));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mf.delete();
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) pend[i] = 0;
        err_m = 1'b0;
        chk({tag, ".we"}, 64'(WriteEn), 64'(0));
        chk({tag, ".rd"}, 64'(rd), 64'(0));
        chk({tag, ".data"}, 64'(InputData), 64'(0));
        chk({tag, ".err"}, 64'(err_addr), 64'(0));
        chk({tag, ".ready"}, 64'(mem_ready), 64'(1));
        chk({tag, ".busy1"}, 64'(rs1_busy), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) pend[i] = 0;
        do_reset("rst0");

        // Single ALU write, then idle.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        cycle("alu");
        idle();
        cycle("alu_idle");

        // Load issue, buffered result, retire.
        q_rs1 = 5'd5; q_rs2 = 5'd20;
        ld_issue = 1'b1; ld_rd = 5'd5;
        cycle("ld_issue");
        idle();
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h12;
        cycle("ld_push");
        idle();
        cycle("ld_pop");
        cycle("ld_done");

        // Fill the FIFO under continuous ALU traffic, reject a push while full, drain.
        for (int i = 0; i < Depth; i++) begin
            alu_valid = 1'b1; alu_rd = ADDR_W'(1 + i); alu_data = 32'h100 + 32'(i);
            mem_valid = 1'b1; mem_rd = ADDR_W'(8 + i); mem_data = 32'hA0 + 32'(i);
            cycle("fill");
        end
        alu_rd = 5'd13; mem_rd = 5'd12; mem_data = 32'hBAD;
        cycle("full");
        idle();
        for (int i = 0; i < Depth + 2; i++) cycle("drain");

        // ALU and FIFO head contend; ALU first.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        cycle("arb_load");
        mem_valid = 1'b0; alu_rd = 5'd2; alu_data = 32'h22;
        cycle("arb_alu");
        idle();
        cycle("arb_fifo");
        cycle("arb_idle");

        // Two loads to x4, retired one at a time.
        q_rs1 = 5'd4; q_rs2 = 5'd6;
        ld_issue = 1'b1; ld_rd = 5'd4;
        cycle("ld4_a");
        cycle("ld4_b");
        idle();
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h41;
        cycle("ld4_push1");
        idle();
        cycle("ld4_pop1");
        cycle("ld4_hold");
        mem_valid = 1'b1; mem_data = 32'h42;
        cycle("ld4_push2");
        idle();
        cycle("ld4_pop2");
        cycle("ld4_clear");

        // Issue and retire of x6 in the same cycle leaves the count unchanged.
        ld_issue = 1'b1; ld_rd = 5'd6;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h61;
        cycle("ld6_issue_push");
        mem_valid = 1'b0;
        cycle("ld6_issue_retire");
        idle();
        mem_valid = 1'b1; mem_data = 32'h62;
        cycle("ld6_push");
        idle();
        cycle("ld6_pop");
        cycle("ld6_clear");

        // Saturate x9, then retire seven times; also retire x10 with nothing pending.
        q_rs1 = 5'd9; q_rs2 = 5'd10;
        ld_issue = 1'b1; ld_rd = 5'd9;
        for (int i = 0; i < 9; i++) cycle("sat_issue");
        idle();
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA10;
        cycle("underflow_push");
        mem_rd = 5'd9;
        for (int i = 0; i < PendMax; i++) begin
            mem_data = 32'h900 + 32'(i);
            cycle("sat_retire");
        end
        idle();
        cycle("sat_drain");
        cycle("sat_clear");

        // Dropped writes: x0 and out-of-range; error is sticky until reset.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0BAD;
        cycle("x0");
        alu_rd = 5'd20; alu_data = 32'h20BAD;
        cycle("oor");
        idle();
        for (int i = 0; i < 3; i++) cycle("err_sticky");
        do_reset("rst_err");

        // Reset mid-operation discards buffered loads and ignores a load issued in reset.
        q_rs1 = 5'd3; q_rs2 = 5'd8;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h80;
        cycle("mid_push1");
        mem_rd = 5'd9; mem_data = 32'h90;
        cycle("mid_push2");
        idle();
        ld_issue = 1'b1; ld_rd = 5'd3;
        do_reset("rst_mid");
        idle();
        for (int i = 0; i < 3; i++) cycle("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
